// File: rtl/serial_tx_arbiter_pkg.sv
// serial_tx_pkg: shared types and sizing helpers for the serial TX arbiter.
//   state_e      : arbiter FSM state (IDLE / SHIFT)
//   WORD_W_DEF   : default parallel word width
//   NUM_CH_DEF   : default number of requesting channels
//   frame_len()  : serial frame length for a given word width
// Optional feature macro: SERIAL_TX_ARBITER_PARITY_EN appends an even-parity
// bit to every frame, making the frame one bit longer than the word.
package serial_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int WORD_W_DEF = 4;
  localparam int NUM_CH_DEF = 4;

  function automatic int frame_len(input int word_w);
`ifdef SERIAL_TX_ARBITER_PARITY_EN
    return word_w + 1;
`else
    return word_w;
`endif
  endfunction

endpackage

// File: rtl/serial_tx_arbiter_p2s_shifter.sv
// p2s_shifter: parallel-to-serial load/shift register with bit counter.
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous, active-high reset
//   load_i       : load data_in_i and restart the bit counter
//   shift_en_i   : advance one bit (ignored when load_i is high)
//   data_in_i    : parallel word to serialize, LSB first
//   bit_out_o    : current frame bit
//   last_bit_o   : current bit is the final bit of the frame
// Macro SERIAL_TX_ARBITER_PARITY_EN: frame carries an extra even-parity bit.
module p2s_shifter
  import serial_tx_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int FRAME_LEN = frame_len(WORD_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              shift_en_i,
  input  logic [WORD_W-1:0] data_in_i,
  output logic              bit_out_o,
  output logic              last_bit_o
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [FRAME_LEN-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_LEN-1:0] load_word;

`ifdef SERIAL_TX_ARBITER_PARITY_EN
  // Parity rides in the MSB so it falls out after the data bits.
  assign load_word = {^data_in_i, data_in_i};
`else
  assign load_word = data_in_i;
`endif

  assign bit_out_o  = shift_q[0];
  assign last_bit_o = (cnt_q == CNT_W'(FRAME_LEN - 1));

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      // A load on the last bit replaces the old frame without a bubble.
      shift_d = load_word;
      cnt_d   = '0;
    end else if (shift_en_i) begin
      shift_d = shift_q >> 1;
      cnt_d   = last_bit_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin arbiter feeding a single LSB-first serial line.
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous, active-high reset
//   req_valid_i  : per-channel word-available flags
//   req_data_i   : packed words, channel i at [i*WORD_W +: WORD_W]
//   req_ready_o  : one-hot (or zero) accept strobe to the winning channel
//   serial_o     : serialized frame bit
//   valid_o      : serial_o carries a frame bit
//   sof_o        : first bit of a frame
//   chan_o       : channel owning the current frame (held in IDLE)
//   busy_o       : frame in flight
// Macro SERIAL_TX_ARBITER_PARITY_EN: each frame ends with an even-parity bit.
module serial_tx_arbiter
  import serial_tx_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_valid_i,
  input  logic [NUM_CH*WORD_W-1:0] req_data_i,
  output logic [NUM_CH-1:0]        req_ready_o,
  output logic                     serial_o,
  output logic                     valid_o,
  output logic                     sof_o,
  output logic [$clog2(NUM_CH)-1:0] chan_o,
  output logic                     busy_o
);

  localparam int CH_W      = $clog2(NUM_CH);
  localparam int FRAME_LEN = frame_len(WORD_W);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic [CH_W-1:0]   chan_q, chan_d;
  logic              sof_q, sof_d;

  logic [WORD_W-1:0] data_arr [NUM_CH];
  logic [CH_W-1:0]   grant_idx;
  logic              grant_found;
  logic              ready_cycle;
  logic              accept;
  logic              bit_out;
  logic              last_bit;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign data_arr[gi] = req_data_i[gi*WORD_W +: WORD_W];
  end

  // Round-robin search starting just after the last accepted channel.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = (int'(last_grant_q) + k) % NUM_CH;
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(cand);
      end
    end
  end

  // Ready in IDLE and on the final frame bit so frames run back to back.
  // Reset is folded in so the accept strobe stays low while reset is held.
  assign ready_cycle = (state_q == IDLE) || last_bit;
  assign accept      = ready_cycle && grant_found && !reset;

  always_comb begin
    req_ready_o = '0;
    if (accept) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    chan_d       = chan_q;
    sof_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit && !accept) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      last_grant_d = grant_idx;
      chan_d       = grant_idx;
      sof_d        = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= CH_W'(NUM_CH - 1);
      chan_q       <= '0;
      sof_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      chan_q       <= chan_d;
      sof_q        <= sof_d;
    end
  end

  p2s_shifter #(
    .WORD_W    (WORD_W),
    .FRAME_LEN (FRAME_LEN)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (accept),
    .shift_en_i (state_q == SHIFT),
    .data_in_i  (data_arr[grant_idx]),
    .bit_out_o  (bit_out),
    .last_bit_o (last_bit)
  );

  // The shifter may still hold stale bits after a frame ends; mask them.
  assign busy_o   = (state_q == SHIFT);
  assign valid_o  = busy_o;
  assign serial_o = busy_o && bit_out;
  assign sof_o    = busy_o && sof_q;
  assign chan_o   = chan_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter (NUM_CH=4, WORD_W=4).
module tb_serial_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [3:0]  req_ready_o;
  logic        serial_o;
  logic        valid_o;
  logic        sof_o;
  logic [1:0]  chan_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_tx_arbiter #(.NUM_CH(4), .WORD_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready_o),
    .serial_o    (serial_o),
    .valid_o     (valid_o),
    .sof_o       (sof_o),
    .chan_o      (chan_o),
    .busy_o      (busy_o)
  );

  typedef struct {
    logic [3:0]  v;
    logic [15:0] d;
    logic [3:0]  rdy;
    logic        ser;
    logic        vld;
    logic        sof;
    logic [1:0]  ch;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] v, input logic [15:0] d,
                              input logic [3:0] rdy, input logic ser,
                              input logic vld, input logic sof,
                              input logic [1:0] ch, input logic busy);
    vec_t r;
    r.v = v; r.d = d; r.rdy = rdy; r.ser = ser;
    r.vld = vld; r.sof = sof; r.ch = ch; r.busy = busy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  // Output bundle: {ready[3:0], serial, valid, sof, chan[1:0], busy}
  function automatic logic [31:0] outs();
    return 32'({req_ready_o, serial_o, valid_o, sof_o, chan_o, busy_o});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at a falling edge with reset released, so the next
  // rising edge is the first one after reset.
  task automatic do_reset();
    req_valid = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_table(input string name);
    foreach (tbl[i]) begin
      req_valid = tbl[i].v;
      req_data  = tbl[i].d;
      #1;
      chk($sformatf("%s[%0d]", name, i), outs(),
          32'({tbl[i].rdy, tbl[i].ser, tbl[i].vld, tbl[i].sof, tbl[i].ch, tbl[i].busy}));
      tick();
    end
    tbl.delete();
  endtask

  int grants[$];
  int bad_ready;

  initial begin
    // Reset holds every output low even with all requests pending.
    reset = 1'b1;
    req_valid = 4'b1111;
    req_data = 16'h8421;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 32'd0);

`ifndef SERIAL_TX_ARBITER_PARITY_EN
    // Single channel: ch1 sends 4'hA -> bits 0,1,0,1, then IDLE holding chan 1.
    do_reset();
    tbl.push_back(mk(4'b0010, 16'h00A0, 4'b0010, 0, 0, 0, 2'd0, 0));
    tbl.push_back(mk(4'b0000, 16'h00A0, 4'b0000, 0, 1, 1, 2'd1, 1));
    tbl.push_back(mk(4'b0000, 16'h00A0, 4'b0000, 1, 1, 0, 2'd1, 1));
    tbl.push_back(mk(4'b0000, 16'h00A0, 4'b0000, 0, 1, 0, 2'd1, 1));
    tbl.push_back(mk(4'b0000, 16'h00A0, 4'b0000, 1, 1, 0, 2'd1, 1));
    tbl.push_back(mk(4'b0000, 16'h00A0, 4'b0000, 0, 0, 0, 2'd1, 0));
    run_table("single_ch1");

    // All four valid: grants 0,1,2,3,0 with no gap in valid_o.
    do_reset();
    tbl.push_back(mk(4'b1111, 16'h8421, 4'b0001, 0, 0, 0, 2'd0, 0));
    tbl.push_back(mk(4'b1111, 16'h8421, 4'b0000, 1, 1, 1, 2'd0, 1));
    tbl.push_back(mk(4'b1111, 16'h8421, 4'b0000, 0, 1, 0, 2'd0, 1));
    tbl.push_back(mk(4'b1111, 16'h8421, 4'b0000, 0, 1, 0, 2'd0, 1));
    tbl.push_back(mk(4'b1111, 16'h8421, 4'b0010, 0, 1, 0, 2'd0, 1));
    tbl.push_back(mk(4'b1111, 16'h8421, 4'b0000, 0, 1, 1, 2'd1, 1));
    tbl.push_back(mk(4'b1111, 16'h8421, 4'b0000, 1, 1, 0, 2'd1, 1));
    tbl.push_back(mk(4'b1111, 16'h8421, 4'b0000, 0, 1, 0, 2'd1, 1));
    tbl.push_back(mk(4'b1111, 16'h8421, 4'b0100, 0, 1, 0, 2'd1, 1));
    tbl.push_back(mk(4'b1111, 16'h8421, 4'b0000, 0, 1, 1, 2'd2, 1));
    tbl.push_back(mk(4'b1111, 16'h8421, 4'b0000, 0, 1, 0, 2'd2, 1));
    tbl.push_back(mk(4'b1111, 16'h8421, 4'b0000, 1, 1, 0, 2'd2, 1));
    tbl.push_back(mk(4'b1111, 16'h8421, 4'b1000, 0, 1, 0, 2'd2, 1));
    tbl.push_back(mk(4'b1111, 16'h8421, 4'b0000, 0, 1, 1, 2'd3, 1));
    tbl.push_back(mk(4'b1111, 16'h8421, 4'b0000, 0, 1, 0, 2'd3, 1));
    tbl.push_back(mk(4'b1111, 16'h8421, 4'b0000, 0, 1, 0, 2'd3, 1));
    tbl.push_back(mk(4'b1111, 16'h8421, 4'b0001, 1, 1, 0, 2'd3, 1));
    tbl.push_back(mk(4'b1111, 16'h8421, 4'b0000, 1, 1, 1, 2'd0, 1));
    run_table("all_four");

    // Only ch0 and ch2 valid: grants alternate, ch1/ch3 never readied.
    do_reset();
    req_valid = 4'b0101;
    req_data  = 16'h0503;
    bad_ready = 0;
    grants.delete();
    for (int c = 0; c < 13; c++) begin
      #1;
      if ((req_ready_o & 4'b1010) != 4'b0000) bad_ready++;
      case (req_ready_o)
        4'b0001: grants.push_back(0);
        4'b0100: grants.push_back(2);
        default: ;
      endcase
      tick();
    end
    chk("alt_grant_count", 32'(grants.size()), 32'd4);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("alt_grant[%0d]", g),
          (g < grants.size()) ? 32'(grants[g]) : 32'hFFFF_FFFF,
          (g % 2 == 0) ? 32'd0 : 32'd2);
    end
    chk("alt_no_ch1_ch3_ready", 32'(bad_ready), 32'd0);

    // Reset on the 2nd bit of a ch3 frame aborts it; priority restarts at ch0.
    do_reset();
    req_valid = 4'b1000;
    req_data  = 16'h6000;
    #1;
    chk("rst_mid_accept3", 32'(req_ready_o), 32'h8);
    tick();
    req_valid = 4'b0000;
    chk("rst_mid_bit0", 32'({serial_o, valid_o, chan_o}), 32'b0_1_11);
    tick();
    chk("rst_mid_bit1_pre", 32'({serial_o, valid_o}), 32'b1_1);
    reset = 1'b1;
    #1;
    chk("rst_mid_drop", outs(), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("rst_no_replay", 32'({valid_o, busy_o}), 32'd0);
    req_valid = 4'b1001;
    req_data  = 16'h6005;
    #1;
    chk("rst_prio_ch0", 32'(req_ready_o), 32'h1);
    tick();
    chk("rst_new_frame", 32'({serial_o, valid_o, sof_o, chan_o}), 32'b1_1_1_00);

    // Requester gap: ch2 4'hF, idle 3 cycles, then ch2 4'h1.
    do_reset();
    req_valid = 4'b0100;
    req_data  = 16'h0F00;
    #1;
    chk("gap_accept", 32'(req_ready_o), 32'h4);
    tick();
    req_valid = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("gap_bit%0d", b), 32'({serial_o, valid_o, chan_o}), 32'b1_1_10);
      tick();
    end
    for (int b = 0; b < 3; b++) begin
      chk($sformatf("gap_idle%0d", b), 32'({busy_o, valid_o, serial_o}), 32'd0);
      tick();
    end
    req_valid = 4'b0100;
    req_data  = 16'h0100;
    #1;
    chk("gap_reaccept", 32'(req_ready_o), 32'h4);
    tick();
    req_valid = 4'b0000;
    chk("gap_new_first", 32'({serial_o, valid_o, sof_o, chan_o}), 32'b1_1_1_10);
`else
    // Parity: ch0 4'h7 -> 1,1,1,0 then parity 1; next accept on parity bit.
    do_reset();
    req_valid = 4'b0001;
    req_data  = 16'h0007;
    #1;
    chk("par_accept", 32'(req_ready_o), 32'h1);
    tick();
    for (int b = 0; b < 5; b++) begin
      logic [3:0] exp_rdy;
      logic       exp_ser;
      exp_rdy = (b == 4) ? 4'b0001 : 4'b0000;
      exp_ser = (b == 3) ? 1'b0 : 1'b1;
      chk($sformatf("par_bit%0d", b), 32'({req_ready_o, serial_o, valid_o, sof_o}),
          32'({exp_rdy, exp_ser, 1'b1, (b == 0)}));
      tick();
    end
    chk("par_next_frame", 32'({serial_o, valid_o, sof_o, chan_o}), 32'b1_1_1_00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always ends by itself.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
